// File: rtl/user_spi_cs_pkg.sv
// Register map, field positions, OBI bus types and sequencer state encoding
// shared by the SPI chip-select controller and its timing sequencer.
package user_spi_cs_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_ID_W   = 4;

    typedef struct packed {
        logic                    req;
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
        logic [OBI_ID_W-1:0]     aid;
    } sbr_obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
        logic [OBI_ID_W-1:0]   rid;
        logic                  r_optional;
    } sbr_obi_rsp_t;

    localparam logic [11:0] REG_CTRL_OFF   = 12'h000;
    localparam logic [11:0] REG_TIMING_OFF = 12'h004;
    localparam logic [11:0] REG_STATUS_OFF = 12'h008;

    localparam int unsigned CTRL_DC_BIT      = 16;
    localparam int unsigned TIMING_SETUP_LSB = 0;
    localparam int unsigned TIMING_HOLD_LSB  = 8;
    localparam int unsigned STATUS_BUSY_BIT  = 0;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_HOLD  = 2'd1,
        SEQ_SETUP = 2'd2
    } seq_state_e;

    function automatic logic multi_bit_set(input logic [15:0] mask);
        return (mask & (mask - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/user_spi_cs_seq.sv
// Break-before-make chip-select sequencer: HOLD with all CS released, then
// SETUP, then the new mask is driven together with the return to IDLE.
module user_spi_cs_seq
    import user_spi_cs_pkg::*;
#(
    parameter int unsigned NUM_CS = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [NUM_CS-1:0] mask_i,
    input  logic [7:0]        setup_i,
    input  logic [7:0]        hold_i,
    output logic [NUM_CS-1:0] applied_o,
    output logic              busy_o
);

    seq_state_e        state_q;
    logic [7:0]        cnt_q;
    logic [7:0]        setup_q;
    logic [NUM_CS-1:0] target_q;
    logic [NUM_CS-1:0] applied_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SEQ_IDLE;
            cnt_q     <= 8'd0;
            setup_q   <= 8'd0;
            target_q  <= '0;
            applied_q <= '0;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (start_i) begin
                        target_q <= mask_i;
                        setup_q  <= setup_i;
                        if (applied_q != '0) begin
                            // Release every CS first; a zero-length phase is skipped outright.
                            applied_q <= '0;
                            if (hold_i != 8'd0) begin
                                state_q <= SEQ_HOLD;
                                cnt_q   <= hold_i - 8'd1;
                            end else if (mask_i != '0 && setup_i != 8'd0) begin
                                state_q <= SEQ_SETUP;
                                cnt_q   <= setup_i - 8'd1;
                            end else begin
                                applied_q <= mask_i;
                            end
                        end else if (setup_i != 8'd0) begin
                            state_q <= SEQ_SETUP;
                            cnt_q   <= setup_i - 8'd1;
                        end else begin
                            applied_q <= mask_i;
                        end
                    end
                end
                SEQ_HOLD: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (target_q != '0 && setup_q != 8'd0) begin
                        state_q <= SEQ_SETUP;
                        cnt_q   <= setup_q - 8'd1;
                    end else begin
                        state_q   <= SEQ_IDLE;
                        applied_q <= target_q;
                    end
                end
                SEQ_SETUP: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q   <= SEQ_IDLE;
                        applied_q <= target_q;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign applied_o = applied_q;
    assign busy_o    = (state_q != SEQ_IDLE);

endmodule

// File: rtl/user_spi_cs_ctrl.sv
// OBI-mapped SPI chip-select controller (CTRL / TIMING / STATUS registers).
// Define USER_SPI_CS_TIMING_EN to build the setup/hold timing sequencer.
module user_spi_cs_ctrl
    import user_spi_cs_pkg::*;
#(
    parameter int unsigned NUM_CS           = 2,
    parameter int unsigned ADDR_LOCAL_WIDTH = 12,
    parameter logic [7:0]  DEFAULT_SETUP    = 8'd1,
    parameter logic [7:0]  DEFAULT_HOLD     = 8'd1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  sbr_obi_req_t      obi_req_i,
    output sbr_obi_rsp_t      obi_rsp_o,
    output logic [NUM_CS-1:0] spi_cs_no,
    output logic              spi_dc_o,
    output logic              busy_o
);

    logic [ADDR_LOCAL_WIDTH-1:0] local_addr;
    logic                        is_ctrl, is_timing, is_status;
    logic                        ctrl_wr, gnt, acc_err, wr_ok, seq_start;
    logic [NUM_CS-1:0]           new_mask, applied;
    logic                        busy;
    logic [31:0]                 rd_val;

    logic [NUM_CS-1:0] sel_q, sel_d;
    logic              dc_q, dc_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        rid_q, rid_d;

    logic unused_req;
    assign unused_req = ^obi_req_i;

    assign local_addr = obi_req_i.addr[ADDR_LOCAL_WIDTH-1:0];
    assign is_ctrl    = (local_addr == ADDR_LOCAL_WIDTH'(REG_CTRL_OFF));
    assign is_status  = (local_addr == ADDR_LOCAL_WIDTH'(REG_STATUS_OFF));
`ifdef USER_SPI_CS_TIMING_EN
    assign is_timing  = (local_addr == ADDR_LOCAL_WIDTH'(REG_TIMING_OFF));
`else
    assign is_timing  = 1'b0;
`endif

    assign new_mask  = obi_req_i.wdata[NUM_CS-1:0];
    assign ctrl_wr   = obi_req_i.req & obi_req_i.we & is_ctrl;
    // A CTRL write must never land mid-sequence, so it waits for IDLE.
    assign gnt       = obi_req_i.req & ~(ctrl_wr & busy);
    assign acc_err   = ~(is_ctrl | is_timing | is_status)
                     | (obi_req_i.we & is_status)
                     | (obi_req_i.we & is_ctrl & obi_req_i.be[0] & multi_bit_set(16'(new_mask)));
    assign wr_ok     = gnt & obi_req_i.we & ~acc_err;
    assign seq_start = wr_ok & is_ctrl & obi_req_i.be[0] & (new_mask != applied);

`ifdef USER_SPI_CS_TIMING_EN
    logic [7:0] setup_q, setup_d;
    logic [7:0] hold_q, hold_d;

    always_comb begin
        setup_d = setup_q;
        hold_d  = hold_q;
        if (wr_ok && is_timing) begin
            if (obi_req_i.be[0]) setup_d = obi_req_i.wdata[TIMING_SETUP_LSB +: 8];
            if (obi_req_i.be[1]) hold_d  = obi_req_i.wdata[TIMING_HOLD_LSB +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            setup_q <= DEFAULT_SETUP;
            hold_q  <= DEFAULT_HOLD;
        end else begin
            setup_q <= setup_d;
            hold_q  <= hold_d;
        end
    end

    user_spi_cs_seq #(
        .NUM_CS (NUM_CS)
    ) u_seq (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (seq_start),
        .mask_i    (new_mask),
        .setup_i   (setup_q),
        .hold_i    (hold_q),
        .applied_o (applied),
        .busy_o    (busy)
    );
`else
    logic [NUM_CS-1:0] applied_q, applied_d;
    logic [15:0]       unused_timing_defaults;

    assign unused_timing_defaults = {DEFAULT_HOLD, DEFAULT_SETUP};
    assign applied_d = seq_start ? new_mask : applied_q;
    assign applied   = applied_q;
    assign busy      = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) applied_q <= '0;
        else         applied_q <= applied_d;
    end
`endif

    always_comb begin
        rd_val = '0;
        if (is_ctrl) begin
            rd_val[NUM_CS-1:0]  = sel_q;
            rd_val[CTRL_DC_BIT] = dc_q;
        end else if (is_status) begin
            rd_val[STATUS_BUSY_BIT] = busy;
        end
`ifdef USER_SPI_CS_TIMING_EN
        else if (is_timing) begin
            rd_val[TIMING_SETUP_LSB +: 8] = setup_q;
            rd_val[TIMING_HOLD_LSB +: 8]  = hold_q;
        end
`endif
    end

    always_comb begin
        sel_d    = sel_q;
        dc_d     = dc_q;
        rvalid_d = gnt;
        rid_d    = rid_q;
        err_d    = 1'b0;
        rdata_d  = '0;
        if (gnt) begin
            rid_d = obi_req_i.aid;
            err_d = acc_err;
            if (!obi_req_i.we && !acc_err) rdata_d = rd_val;
        end
        if (wr_ok && is_ctrl) begin
            if (obi_req_i.be[0]) sel_d = new_mask;
            if (obi_req_i.be[2]) dc_d  = obi_req_i.wdata[CTRL_DC_BIT];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q    <= '0;
            dc_q     <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            sel_q    <= sel_d;
            dc_q     <= dc_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = gnt;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rdata  = rdata_q;
        obi_rsp_o.err    = err_q;
        obi_rsp_o.rid    = rid_q;
    end

    assign spi_cs_no = ~applied;
    assign spi_dc_o  = dc_q;
    assign busy_o    = busy;

endmodule

// File: tb/tb_user_spi_cs_ctrl.sv
// Scoreboard bench for user_spi_cs_ctrl: the driver predicts responses and the
// per-cycle chip-select waveform; a negedge monitor compares them with the DUT.
module tb_user_spi_cs_ctrl;
    import user_spi_cs_pkg::*;

    localparam int NCS = 2;
`ifdef USER_SPI_CS_TIMING_EN
    localparam bit TIMING_EN = 1'b1;
`else
    localparam bit TIMING_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    sbr_obi_req_t      obi_req_i;
    sbr_obi_rsp_t      obi_rsp_o;
    logic [NCS-1:0]    spi_cs_no;
    logic              spi_dc_o;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    user_spi_cs_ctrl #(.NUM_CS(NCS)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .obi_req_i (obi_req_i),
        .obi_rsp_o (obi_rsp_o),
        .spi_cs_no (spi_cs_no),
        .spi_dc_o  (spi_dc_o),
        .busy_o    (busy_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  rid;
        int unsigned due;
    } rsp_t;

    typedef struct {
        logic           busy;
        logic [NCS-1:0] cs_n;
    } pin_t;

    rsp_t        rsp_q[$];
    pin_t        pin_q[$];
    pin_t        cur_pin;
    rsp_t        mon_r;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic [NCS-1:0] m_sel;
    logic           m_dc;
    logic [7:0]     m_setup, m_hold;

    logic [11:0] bad_off [5] = '{12'h00C, 12'h010, 12'h001, 12'hFFC, 12'h204};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rsp_q.delete();
        pin_q.delete();
        cur_pin = '{busy: 1'b0, cs_n: {NCS{1'b1}}};
        m_sel   = '0;
        m_dc    = 1'b0;
        m_setup = 8'd1;
        m_hold  = 8'd1;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            if (pin_q.size() > 0) cur_pin = pin_q.pop_front();
            check("cs_n", 32'(spi_cs_no), 32'(cur_pin.cs_n));
            check("busy", 32'(busy_o), 32'(cur_pin.busy));
            check("dc", 32'(spi_dc_o), 32'(m_dc));
            if (obi_rsp_o.rvalid) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected: got rvalid=1 rid=%0d, expected no response (cycle %0d)",
                             obi_rsp_o.rid, cyc);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rvalid_latency", cyc, mon_r.due);
                    check("rid", 32'(obi_rsp_o.rid), 32'(mon_r.rid));
                    check("err", 32'(obi_rsp_o.err), 32'(mon_r.err));
                    check("rdata", obi_rsp_o.rdata, mon_r.rdata);
                    check("r_optional", 32'(obi_rsp_o.r_optional), 32'd0);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                mon_r = rsp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing: got rvalid=0, expected response rid=%0d (cycle %0d)", mon_r.rid, cyc);
            end
        end
    end

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit rst_after);
        logic [11:0]    off;
        logic [3:0]     aid;
        logic [NCS-1:0] newm;
        bit             is_c, is_t, is_s, ctrl_wr, err, granted;
        rsp_t           e;
        int             n;
        off     = addr[11:0];
        aid     = 4'($urandom);
        newm    = wdata[NCS-1:0];
        is_c    = (off == 12'h000);
        is_t    = TIMING_EN && (off == 12'h004);
        is_s    = (off == 12'h008);
        ctrl_wr = we && is_c;
        err     = !(is_c || is_t || is_s) || (we && is_s) || (we && is_c && be[0] && $countones(newm) > 1);
        granted = 1'b0;
        @(negedge clk_i);
        obi_req_i.req   = 1'b1;
        obi_req_i.addr  = addr;
        obi_req_i.we    = we;
        obi_req_i.be    = be;
        obi_req_i.wdata = wdata;
        obi_req_i.aid   = aid;
        for (int w = 0; w < 400 && !granted; w++) begin
            #1;
            check("gnt", 32'(obi_rsp_o.gnt), 32'(!(ctrl_wr && cur_pin.busy)));
            if (obi_rsp_o.gnt) begin
                granted = 1'b1;
                e.rid   = aid;
                e.err   = err;
                e.due   = cyc + 1;
                e.rdata = '0;
                if (!we && !err) begin
                    if (is_c)      e.rdata = 32'(m_sel) | (32'(m_dc) << 16);
                    else if (is_t) e.rdata = {16'd0, m_hold, m_setup};
                    else           e.rdata = 32'(cur_pin.busy);
                end
                rsp_q.push_back(e);
                @(posedge clk_i);
                if (rst_after) begin
                    #1;
                    rst_ni = 1'b0;
                    model_reset();
                    #1;
                    check("rst_cs_n", 32'(spi_cs_no), 32'({NCS{1'b1}}));
                    check("rst_busy", 32'(busy_o), 32'd0);
                    check("rst_rvalid", 32'(obi_rsp_o.rvalid), 32'd0);
                    check("rst_dc", 32'(spi_dc_o), 32'd0);
                end else if (we && !err) begin
                    if (is_c) begin
                        if (be[2]) m_dc = wdata[16];
                        if (be[0] && newm != m_sel) begin
                            n = 0;
                            if (TIMING_EN)
                                n = (m_sel != '0) ? int'(m_hold) + ((newm != '0) ? int'(m_setup) : 0)
                                                  : int'(m_setup);
                            repeat (n) pin_q.push_back('{busy: 1'b1, cs_n: {NCS{1'b1}}});
                            pin_q.push_back('{busy: 1'b0, cs_n: ~newm});
                            m_sel = newm;
                        end
                    end else if (is_t) begin
                        if (be[0]) m_setup = wdata[7:0];
                        if (be[1]) m_hold  = wdata[15:8];
                    end
                end
            end else begin
                @(negedge clk_i);
            end
        end
        if (!granted) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got gnt=0 for 400 cycles, expected a grant (offset 0x%0h)", off);
        end
        #1;
        obi_req_i = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hi, wd;
        logic [3:0]  be;
        int          k;
        obi_req_i = '0;
        model_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset state
        check("reset_cs_n", 32'(spi_cs_no), 32'({NCS{1'b1}}));
        check("reset_dc", 32'(spi_dc_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        xfer(1'b0, 32'h004, 32'h0, 4'hF, 1'b0);
        xfer(1'b0, 32'h008, 32'h0, 4'hF, 1'b0);
        xfer(1'b0, 32'h000, 32'h0, 4'hF, 1'b0);

        // Setup-only sequence, then a timing write while busy and a stalled switch
        xfer(1'b1, 32'h004, 32'h0000_0203, 4'hF, 1'b0);
        xfer(1'b1, 32'h000, 32'h0000_0001, 4'hF, 1'b0);
        xfer(1'b1, 32'h004, 32'h0000_0201, 4'hF, 1'b0);
        xfer(1'b1, 32'h000, 32'h0001_0002, 4'hF, 1'b0);

        // Errored accesses leave state untouched
        xfer(1'b1, 32'h000, 32'h0000_0003, 4'hF, 1'b0);
        xfer(1'b1, 32'h008, 32'h0000_0001, 4'hF, 1'b0);
        xfer(1'b0, 32'h010, 32'h0, 4'hF, 1'b0);
        xfer(1'b0, 32'h000, 32'h0, 4'hF, 1'b0);
        xfer(1'b0, 32'h004, 32'h0, 4'hF, 1'b0);

        // Same-mask write only changes dc
        xfer(1'b1, 32'h000, 32'h0000_0002, 4'hF, 1'b0);

        for (int i = 0; i < 200; i++) begin
            k  = int'($urandom_range(0, 9));
            hi = $urandom & 32'hFFFF_F000;
            wd = $urandom;
            be = 4'($urandom);
            case (k)
                0, 1, 2: xfer(1'b1, hi | 32'h000, (wd & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)),
                              {be[3:1], 1'b1}, 1'b0);
                3:       xfer(1'b1, hi | 32'h004,
                              {wd[31:16], 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))}, be, 1'b0);
                4:       xfer(1'b0, hi | 32'h000, wd, be, 1'b0);
                5:       xfer(1'b0, hi | 32'h004, wd, be, 1'b0);
                6:       xfer(1'b0, hi | 32'h008, wd, be, 1'b0);
                7:       xfer(1'b1, hi | 32'h008, wd, be, 1'b0);
                8:       xfer(wd[0], hi | 32'(bad_off[$urandom_range(0, 4)]), wd, be, 1'b0);
                default: repeat ($urandom_range(1, 3)) @(negedge clk_i);
            endcase
        end

        // Reset in the middle of a hold phase with a read response in flight
        xfer(1'b1, 32'h000, 32'h0000_0001, 4'hF, 1'b0);
        xfer(1'b1, 32'h004, 32'h0000_0601, 4'hF, 1'b0);
        xfer(1'b1, 32'h000, 32'h0000_0002, 4'hF, 1'b0);
        xfer(1'b0, 32'h008, 32'h0, 4'hF, 1'b1);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            #1;
            check("post_reset_no_rvalid", 32'(obi_rsp_o.rvalid), 32'd0);
        end
        xfer(1'b0, 32'h004, 32'h0, 4'hF, 1'b0);
        xfer(1'b0, 32'h000, 32'h0, 4'hF, 1'b0);

        for (int w = 0; w < 100 && (rsp_q.size() > 0 || pin_q.size() > 0); w++) @(negedge clk_i);
        @(negedge clk_i);
        if (rsp_q.size() > 0 || pin_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d responses and %0d pin states outstanding, expected 0",
                     rsp_q.size(), pin_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
